// File: rtl/bitmap_mem_pkg.sv
// Shared types and constants for the bitmap RAM arbiter.
package bitmap_mem_pkg;
    localparam int BMEM_ADDR_W = 16;
    localparam int BMEM_DATA_W = 1536;

    typedef logic [BMEM_ADDR_W-1:0] bmem_addr_t;
    typedef logic [BMEM_DATA_W-1:0] bmem_row_t;

    typedef enum logic [1:0] {
        RD_SCANOUT = 2'd0,
        RD_CPU     = 2'd1,
        RD_BLIT    = 2'd2
    } bmem_rd_idx_e;

    // Pointer width that stays legal for a single requester.
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/bitmap_mem_arbiter_rr_arbiter.sv
// Round-robin arbiter: lowest requester at or above ptr wins, else wraps to lowest requester.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt
);
    logic [N-1:0] w_hi;
    logic [N-1:0] w_sel;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_mask
            assign w_hi[gi] = i_req[gi] && (PW'(gi) >= i_ptr);
        end
    endgenerate

    assign w_sel = (|w_hi) ? w_hi : i_req;
    assign o_gnt = w_sel & (~w_sel + N'(1));
endmodule

// File: rtl/bitmap_mem_arbiter.sv
// Bitmap RAM port arbiter: reads (starvation guard > scanout urgent > round-robin) and writes (round-robin).
// Optional per-requester performance counters when BMEM_ARB_PERF_EN is defined.
module bitmap_mem_arbiter
    import bitmap_mem_pkg::*;
#(
    parameter int ADDR_W     = BMEM_ADDR_W,
    parameter int DATA_W     = BMEM_DATA_W,
    parameter int N_RD       = 3,
    parameter int N_WR       = 2,
    parameter int STARVE_MAX = 8
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic [N_RD-1:0]          i_rd_req,
    input  logic [N_RD*ADDR_W-1:0]   i_rd_addr,
    input  logic                     i_rd_urgent,
    output logic [N_RD-1:0]          o_rd_gnt,
    output logic [N_RD-1:0]          o_rd_valid,
    output logic [DATA_W-1:0]        o_rd_data,
    input  logic [N_WR-1:0]          i_wr_req,
    input  logic [N_WR*ADDR_W-1:0]   i_wr_addr,
    input  logic [N_WR*DATA_W-1:0]   i_wr_data,
    output logic [N_WR-1:0]          o_wr_gnt,
    output logic [ADDR_W-1:0]        o_mem_rdaddress,
    output logic [ADDR_W-1:0]        o_mem_wraddress,
    output logic                     o_mem_wren,
    output logic [DATA_W-1:0]        o_mem_data,
`ifdef BMEM_ARB_PERF_EN
    input  logic                     i_perf_clear,
    output logic [N_RD*32-1:0]       o_perf_rd_grants,
    output logic [N_RD*32-1:0]       o_perf_rd_stalls,
    output logic [N_WR*32-1:0]       o_perf_wr_grants,
`endif
    input  logic [DATA_W-1:0]        i_mem_q
);
    localparam int RD_PW = ptr_w(N_RD);
    localparam int WR_PW = ptr_w(N_WR);
    localparam int SW    = 8;
    localparam int SCAN  = int'(RD_SCANOUT);

    logic [RD_PW-1:0] r_rd_ptr;
    logic [WR_PW-1:0] r_wr_ptr;
    logic [N_RD-1:0]  r_rd_valid;
    logic [N_RD-1:0]  w_rd_rr_gnt, w_rd_gnt, w_forced;
    logic [N_WR-1:0]  w_wr_rr_gnt, w_wr_gnt;
    logic [N_RD-1:0]  w_rd_addr_t [ADDR_W];
    logic [N_RD-1:0]  w_rd_ptr_t  [RD_PW];
    logic [N_WR-1:0]  w_wr_addr_t [ADDR_W];
    logic [N_WR-1:0]  w_wr_data_t [DATA_W];
    logic [N_WR-1:0]  w_wr_ptr_t  [WR_PW];
    logic [RD_PW-1:0] w_rd_ptr_next;
    logic [WR_PW-1:0] w_wr_ptr_next;
    logic             w_urgent;

    rr_arbiter #(.N(N_RD), .PW(RD_PW)) u_rd_rr (.i_req(i_rd_req), .i_ptr(r_rd_ptr), .o_gnt(w_rd_rr_gnt));
    rr_arbiter #(.N(N_WR), .PW(WR_PW)) u_wr_rr (.i_req(i_wr_req), .i_ptr(r_wr_ptr), .o_gnt(w_wr_rr_gnt));

    assign w_urgent = i_rd_req[SCAN] && i_rd_urgent;

    always_comb begin
        w_rd_gnt = '0;
        if (!i_reset) begin
            if (|w_forced)
                w_rd_gnt = w_forced & (~w_forced + N_RD'(1));
            else if (w_urgent)
                w_rd_gnt[SCAN] = 1'b1;
            else
                w_rd_gnt = w_rd_rr_gnt;
        end
    end

    assign w_wr_gnt = i_reset ? '0 : w_wr_rr_gnt;

    generate
        for (genvar gi = 0; gi < N_RD; gi++) begin : g_rd
            logic [SW-1:0] r_starve;
            assign w_forced[gi] = i_rd_req[gi] && (r_starve == SW'(STARVE_MAX));
            for (genvar bi = 0; bi < ADDR_W; bi++) begin : g_addr
                assign w_rd_addr_t[bi][gi] = i_rd_addr[gi*ADDR_W + bi] & w_rd_gnt[gi];
            end
            // Next pointer is (granted + 1) mod N_RD, encoded as a constant per requester.
            for (genvar bi = 0; bi < RD_PW; bi++) begin : g_ptr
                assign w_rd_ptr_t[bi][gi] = w_rd_gnt[gi] && ((((gi + 1) % N_RD) >> bi) & 1) != 0;
            end
            always_ff @(posedge i_clock) begin
                if (i_reset || !i_rd_req[gi] || w_rd_gnt[gi])
                    r_starve <= '0;
                else if (r_starve != SW'(STARVE_MAX))
                    r_starve <= r_starve + SW'(1);
            end
`ifdef BMEM_ARB_PERF_EN
            logic [31:0] r_perf_grants, r_perf_stalls;
            always_ff @(posedge i_clock) begin
                if (i_reset || i_perf_clear) begin
                    r_perf_grants <= '0;
                    r_perf_stalls <= '0;
                end else begin
                    if (w_rd_gnt[gi])
                        r_perf_grants <= r_perf_grants + 32'd1;
                    if (i_rd_req[gi] && !w_rd_gnt[gi])
                        r_perf_stalls <= r_perf_stalls + 32'd1;
                end
            end
            assign o_perf_rd_grants[gi*32 +: 32] = r_perf_grants;
            assign o_perf_rd_stalls[gi*32 +: 32] = r_perf_stalls;
`endif
        end

        for (genvar gi = 0; gi < N_WR; gi++) begin : g_wr
            for (genvar bi = 0; bi < ADDR_W; bi++) begin : g_addr
                assign w_wr_addr_t[bi][gi] = i_wr_addr[gi*ADDR_W + bi] & w_wr_gnt[gi];
            end
            for (genvar bi = 0; bi < DATA_W; bi++) begin : g_data
                assign w_wr_data_t[bi][gi] = i_wr_data[gi*DATA_W + bi] & w_wr_gnt[gi];
            end
            for (genvar bi = 0; bi < WR_PW; bi++) begin : g_ptr
                assign w_wr_ptr_t[bi][gi] = w_wr_gnt[gi] && ((((gi + 1) % N_WR) >> bi) & 1) != 0;
            end
`ifdef BMEM_ARB_PERF_EN
            logic [31:0] r_perf_grants;
            always_ff @(posedge i_clock) begin
                if (i_reset || i_perf_clear)
                    r_perf_grants <= '0;
                else if (w_wr_gnt[gi])
                    r_perf_grants <= r_perf_grants + 32'd1;
            end
            assign o_perf_wr_grants[gi*32 +: 32] = r_perf_grants;
`endif
        end

        // Grants are one-hot, so each output bit is a plain OR of the masked inputs.
        for (genvar bi = 0; bi < ADDR_W; bi++) begin : g_addr_or
            assign o_mem_rdaddress[bi] = |w_rd_addr_t[bi];
            assign o_mem_wraddress[bi] = |w_wr_addr_t[bi];
        end
        for (genvar bi = 0; bi < DATA_W; bi++) begin : g_data_or
            assign o_mem_data[bi] = |w_wr_data_t[bi];
        end
        for (genvar bi = 0; bi < RD_PW; bi++) begin : g_rd_ptr_or
            assign w_rd_ptr_next[bi] = |w_rd_ptr_t[bi];
        end
        for (genvar bi = 0; bi < WR_PW; bi++) begin : g_wr_ptr_or
            assign w_wr_ptr_next[bi] = |w_wr_ptr_t[bi];
        end
    endgenerate

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_rd_valid <= '0;
        end else begin
            r_rd_valid <= w_rd_gnt;
            if (|w_rd_gnt)
                r_rd_ptr <= w_rd_ptr_next;
            if (|w_wr_gnt)
                r_wr_ptr <= w_wr_ptr_next;
        end
    end

    // Reset masks the in-flight return so a discarded read never shows up.
    assign o_rd_valid = i_reset ? '0 : r_rd_valid;
    assign o_rd_data  = i_mem_q;
    assign o_rd_gnt   = w_rd_gnt;
    assign o_wr_gnt   = w_wr_gnt;
    assign o_mem_wren = |w_wr_gnt;
endmodule
